// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage for the 9-bit accumulator CPU.
// Decodes the opcode into the datapath control bundle, holds it in an output
// register behind a valid/ready handshake, stalls one cycle on load-use
// hazards, discards state on flush and latches a sticky halt.
module decode_stage #(
  parameter int INSTR_W  = 9,
  parameter int REG_AW   = 4,
  parameter int ADR_REG  = 4,
  parameter int MATH_REG = 5,
  parameter int CNT_REG  = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  readReg0,
  output logic [REG_AW-1:0]  readReg1,
  output logic [REG_AW-1:0]  write_reg,
  output logic [3:0]         ALUOp,
  output logic               write,
  output logic               move,
  output logic               MemtoReg,
  output logic               MemWrite,
  output logic               branch,
  output logic               immediate,
  output logic               set_quarter,
  output logic               jump_sign,
  output logic               start,
  output logic               halted,
  output logic               illegal
);

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_MV, OP_SET_ADR, OP_MV_ADR, OP_RS_ADR, OP_SETI,
    OP_MV_MATH, OP_MV_TO_MATH, OP_MATH_TO_ADR, OP_SET_REG, OP_SET_CNT,
    OP_MV_CNT, OP_MV_TO_CNT, OP_RS_CNT, OP_BE, OP_BNE, OP_BEZ, OP_BLTZ,
    OP_BGTE, OP_EVU, OP_EVL, OP_LD, OP_ST, OP_JUMP, OP_ZERO_REG, OP_HALT
  } opcode_e;

  typedef struct packed {
    logic [REG_AW-1:0] read_reg0;
    logic [REG_AW-1:0] read_reg1;
    logic [REG_AW-1:0] write_reg;
    logic [3:0]        alu_op;
    logic              write;
    logic              move;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch;
    logic              immediate;
    logic              set_quarter;
    logic              jump_sign;
    logic              start;
  } bundle_t;

  localparam logic [REG_AW-1:0] ADR  = REG_AW'(ADR_REG);
  localparam logic [REG_AW-1:0] MATH = REG_AW'(MATH_REG);
  localparam logic [REG_AW-1:0] CNT  = REG_AW'(CNT_REG);

  logic [4:0]        opcode;
  logic [REG_AW-1:0] rs, rd;
  bundle_t           dec, bundle_q;
  logic              src0, src1, op_illegal;
  logic              hazard, held_halt, accept;

  assign opcode = instruction_in[INSTR_W-1 -: 5];
  assign rs     = REG_AW'(instruction_in[3:2]);
  assign rd     = REG_AW'(instruction_in[1:0]);

  // Combinational opcode decode into the control bundle plus source-use flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dec        = '0;
    op_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        dec.read_reg0 = rs;   dec.read_reg1 = MATH; dec.write_reg = rd;
        dec.write     = 1'b1; dec.alu_op    = (opcode == OP_SUB) ? 4'd1 : 4'd0;
      end
      OP_MV: begin
        dec.read_reg0 = rs; dec.read_reg1 = MATH; dec.write_reg = rd;
        dec.write = 1'b1; dec.move = 1'b1;
      end
      OP_SET_ADR:     begin dec.read_reg0 = rs;   dec.write_reg = ADR;  dec.write = 1'b1; dec.move = 1'b1; end
      OP_MV_ADR:      begin dec.read_reg0 = ADR;  dec.write_reg = rd;   dec.write = 1'b1; dec.move = 1'b1; end
      OP_RS_ADR: begin
        dec.write_reg = ADR; dec.write = 1'b1; dec.immediate = 1'b1;
        dec.jump_sign = instruction_in[0];
      end
      OP_SETI: begin
        dec.read_reg0 = REG_AW'(instruction_in[3:0]); dec.write_reg = MATH;
        dec.write = 1'b1; dec.immediate = 1'b1;
      end
      OP_MV_MATH:     begin dec.read_reg0 = MATH; dec.write_reg = rd;   dec.write = 1'b1; dec.move = 1'b1; end
      OP_MV_TO_MATH:  begin dec.read_reg0 = rs;   dec.write_reg = MATH; dec.write = 1'b1; dec.move = 1'b1; end
      OP_MATH_TO_ADR: begin dec.read_reg0 = MATH; dec.write_reg = ADR;  dec.write = 1'b1; dec.move = 1'b1; end
      OP_SET_REG: begin
        dec.read_reg0 = MATH; dec.read_reg1 = rs; dec.write_reg = rd;
        dec.write = 1'b1; dec.move = 1'b1; dec.set_quarter = 1'b1;
      end
      OP_SET_CNT: begin
        dec.read_reg0 = rd; dec.read_reg1 = rs; dec.write_reg = CNT;
        dec.write = 1'b1; dec.set_quarter = 1'b1;
      end
      OP_MV_CNT:      begin dec.read_reg0 = CNT;  dec.write_reg = rd;   dec.write = 1'b1; dec.move = 1'b1; end
      OP_MV_TO_CNT:   begin dec.read_reg0 = rs;   dec.write_reg = CNT;  dec.write = 1'b1; dec.move = 1'b1; end
      OP_RS_CNT:      begin dec.write_reg = CNT;  dec.write = 1'b1; dec.immediate = 1'b1; end
      OP_BE, OP_BNE, OP_BEZ, OP_BLTZ, OP_BGTE: begin
        dec.branch = 1'b1; dec.read_reg0 = rs; dec.read_reg1 = rd;
        case (opcode)
          OP_BE:   dec.alu_op = 4'd7;
          OP_BNE:  dec.alu_op = 4'd8;
          OP_BEZ:  dec.alu_op = 4'd6;
          OP_BLTZ: dec.alu_op = 4'd5;
          default: dec.alu_op = 4'd4;
        endcase
      end
      OP_EVU, OP_EVL: begin
        dec.read_reg0 = rs; dec.write_reg = rd;
        dec.alu_op    = (opcode == OP_EVL) ? 4'd3 : 4'd2;
      end
      OP_LD: begin
        dec.read_reg0 = rs; dec.read_reg1 = ADR; dec.write_reg = rd;
        dec.write = 1'b1; dec.mem_to_reg = 1'b1;
      end
      OP_ST:        begin dec.read_reg0 = rs; dec.read_reg1 = ADR; dec.mem_write = 1'b1; end
      OP_JUMP:      begin dec.branch = 1'b1; dec.alu_op = 4'd7; end
      OP_ZERO_REG:  begin dec.write_reg = rd; dec.write = 1'b1; dec.immediate = 1'b1; end
      OP_HALT:      dec.start = 1'b1;
      default:      op_illegal = 1'b1;
    endcase
  end

  // Which decoded register addresses are real sources (for hazard compare).
  always_comb begin
    src0 = (opcode <= 5'd23) && (opcode != OP_RS_ADR) && (opcode != OP_SETI) &&
           (opcode != OP_RS_CNT);
    src1 = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_SET_REG) ||
           (opcode == OP_SET_CNT) || ((opcode >= OP_BE) && (opcode <= OP_BGTE)) ||
           (opcode == OP_LD) || (opcode == OP_ST);
  end

  // Load-use check against the held ld, and the handshake acceptance logic.
  always_comb begin
    hazard    = out_valid && bundle_q.mem_to_reg &&
                ((src0 && (dec.read_reg0 == bundle_q.write_reg)) ||
                 (src1 && (dec.read_reg1 == bundle_q.write_reg)));
    held_halt = out_valid && bundle_q.start;
    in_ready  = !reset && !flush && !halted && !held_halt && !hazard &&
                (!out_valid || out_ready);
    accept    = in_valid && in_ready;
  end

  // Output register: reset > flush > accept > drain to bubble > hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      out_valid <= 1'b0;
      bundle_q  <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      bundle_q  <= '0;
      illegal   <= 1'b0;
    end else begin
      if (out_valid && out_ready && bundle_q.start) halted <= 1'b1;
      illegal <= accept && op_illegal;
      if (accept) begin
        out_valid <= !op_illegal;
        bundle_q  <= op_illegal ? '0 : dec;
      end else if (!out_valid || out_ready) begin
        out_valid <= 1'b0;
        bundle_q  <= '0;
      end
    end
  end

  assign readReg0    = bundle_q.read_reg0;
  assign readReg1    = bundle_q.read_reg1;
  assign write_reg   = bundle_q.write_reg;
  assign ALUOp       = bundle_q.alu_op;
  assign write       = bundle_q.write;
  assign move        = bundle_q.move;
  assign MemtoReg    = bundle_q.mem_to_reg;
  assign MemWrite    = bundle_q.mem_write;
  assign branch      = bundle_q.branch;
  assign immediate   = bundle_q.immediate;
  assign set_quarter = bundle_q.set_quarter;
  assign jump_sign   = bundle_q.jump_sign;
  assign start       = bundle_q.start;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage for the 9-bit accumulator-style CPU. It accepts one instruction per cycle over a valid/ready handshake and decodes the opcode into the datapath control bundle. It holds that bundle in an output register and detects load-use hazards against the instruction already held, inserting a one-cycle bubble when needed. It also supports flushing on a taken branch and latches a sticky halt. It sits between instruction fetch and register read/execute.

## Interface
- INSTR_W, 9: instruction width; opcode = instruction_in[INSTR_W-1:INSTR_W-5].
- REG_AW, 4: register-address width; 2-bit instruction fields zero-extend to REG_AW.
- ADR_REG, 4: index of $adr.
- MATH_REG, 5: index of $math.
- CNT_REG, 7: index of $cnt.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  instruction_in valid.
- in_ready  out  1  stage accepts instruction this cycle (combinational).
- instruction_in  in  INSTR_W  instruction; rs=[3:2], rd=[1:0].
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream consumes bundle.
- readReg0, readReg1, write_reg  out  REG_AW each  register addresses.
- ALUOp  out  4  ALU operation.
- write, move, MemtoReg, MemWrite, branch, immediate, set_quarter, jump_sign, start  out  1 each  control flags.
- halted  out  1  sticky halt.
- illegal  out  1  one-cycle pulse when an opcode ≥ 27 is accepted.

## Operation
- Default for every field is 0. Listed fields override the default. R=rs, D=rd.
- Opcodes 0 add / 1 sub: r0=R, r1=MATH, wr=D, write; ALUOp 0 / 1.
- Opcode 2 mv: r0=R, r1=MATH, wr=D, write, move.
- Opcode 3 setAdr: r0=R, wr=ADR, write, move.
- Opcode 4 mvAdr: r0=ADR, wr=D, write, move.
- Opcode 5 rsAdr: wr=ADR, write, immediate, jump_sign=instr[0].
- Opcode 6 seti: r0=instr[3:0], wr=MATH, write, immediate.
- Opcodes 7 mvMath / 8 mvToMath / 9 mathToAdr: move+write; (r0,wr) = (MATH,D) / (R,MATH) / (MATH,ADR).
- Opcode 10 setReg: r0=MATH, r1=R, wr=D, write, move, set_quarter.
- Opcode 11 setCnt: r0=D, r1=R, wr=CNT, write, set_quarter.
- Opcode 12 mvCnt: r0=CNT, wr=D, write, move.
- Opcode 13 mvToCnt: r0=R, wr=CNT, write, move.
- Opcode 14 rsCnt: wr=CNT, write, immediate.
- Opcodes 15–19 be/bne/bez/bltz/bgte: branch, r0=R, r1=D; ALUOp 7/8/6/5/4.
- Opcodes 20 evu / 21 evl: r0=R, wr=D; ALUOp 2 / 3; no write.
- Opcode 22 ld: r0=R, r1=ADR, wr=D, write, MemtoReg; ALUOp 0.
- Opcode 23 st: r0=R, r1=ADR, MemWrite; ALUOp 0.
- Opcode 24 jump: branch; ALUOp 7.
- Opcode 25 zeroReg: wr=D, write, immediate.
- Opcode 26 halt: start=1.
- Opcodes 27–31: treated as a bubble (no out_valid), with illegal pulsed.
- Source use:
  - r0 is a source for all opcodes 0–23 except 5, 6, 14.
  - r1 is a source for opcodes 0, 1, 10, 11, 15–19, 22, 23.
- Load-use hazard: the output register holds an ld (out_valid && MemtoReg) and the incoming instruction uses r0 or r1 equal to the held write_reg. Then in_ready=0 for that cycle. If out_ready, the register is loaded with a bubble (out_valid=0), and the instruction is accepted on the next cycle.
- Logic: in_ready = !reset && !flush && !halted && !held_halt && !hazard && (!out_valid || out_ready).
- held_halt = out_valid && start.
- halted sets when a halt bundle is consumed (out_valid && out_ready && start). It clears only on reset.

## Timing
- Reset: out_valid=0, all bundle fields=0, halted=0, illegal=0; in_ready=0 while reset is high.
- Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
- Throughput: 1 instruction/cycle when there is no hazard and out_ready=1.
- Backpressure: out_valid && !out_ready holds the bundle stable; in_ready=0.
- Flush priority is reset > flush > everything else. Flush gives out_valid=0 next cycle and a held halt is discarded (halted stays 0). An instruction presented during flush is not accepted.
- Illegal opcode: illegal=1 in the cycle after acceptance, with out_valid=0 that cycle.
- Reset mid-stall or mid-hazard: all state clears, and the next accept is possible on the first cycle after reset deasserts.

## Test plan
- Reset, then stream add(0x00C, R=3,D=0) and sub(0x019) with out_ready=1 → out_valid each following cycle:
  - add: r0=3, r1=5, wr=0, write=1, ALUOp=0.
  - sub: r0=2, r1=5, wr=1, ALUOp=1.
- ld(0x161, wr=1) then add(0x006, rs=1) → one bubble cycle (out_valid=0, in_ready=0); the add appears 2 cycles after the ld; a non-dependent add (rs=2) shows no bubble.
- Hold out_ready=0 for 3 cycles with setCnt(0x0B6) held → bundle stable (wr=7, r0=2, r1=1, set_quarter=1), in_ready=0 throughout.
- be(0x0F6) held, flush=1 with seti(0x06A) presented → next cycle out_valid=0; seti is not accepted; the re-presented seti decodes r0=10, wr=5, immediate=1.
- halt(0x1A0) consumed → halted=1 next cycle, in_ready stays 0; the same halt flushed before consumption → halted stays 0.
- Opcode 0x1F0 → illegal pulses 1 cycle, out_valid=0; assert reset during a hazard stall → all outputs 0 the next cycle.
